// File: rtl/uart_frame_parser.sv
// Frame parser for the uart_rx byte stream: header hunt, fixed-length payload and CRC-16 check.
// Good frames are published as a flat payload vector with a one-cycle strobe.
module uart_frame_parser #(
   parameter int unsigned PAYLOAD_BYTES  = 4,
   parameter logic [31:0] MAGICNUMBER    = 32'hDABBAD00,
   parameter int unsigned TIMEOUT_CYCLES = 16000
) (
   input  logic                       CLK,
   input  logic                       reset,
   input  logic                       rx_data_ready,
   input  logic [7:0]                 rx_data,
   output logic [8*PAYLOAD_BYTES-1:0] payload,
   output logic                       frame_valid,
   output logic                       crc_error,
   output logic                       frame_timeout,
   output logic [15:0]                good_frames,
   output logic [15:0]                bad_frames
);

   localparam int unsigned IdxW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(PAYLOAD_BYTES - 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StHunt, StPayload, StCrcHi, StCrcLo} state_e;

   state_e                     state_q, state_d;
   logic [31:0]                hdr_q, hdr_d;
   logic [15:0]                crc_q, crc_d;
   logic [7:0]                 crc_rx_hi_q, crc_rx_hi_d;
   logic [IdxW-1:0]            idx_q, idx_d;
   logic [TmoW-1:0]            tmo_q, tmo_d;
   logic [8*PAYLOAD_BYTES-1:0] payload_buf_q, payload_buf_d;
   logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
   logic                       frame_valid_q, frame_valid_d;
   logic                       crc_error_q, crc_error_d;
   logic                       frame_timeout_q, frame_timeout_d;
   logic [15:0]                good_frames_q, good_frames_d;
   logic [15:0]                bad_frames_q, bad_frames_d;

   // CRC-16/CCITT-FALSE, one byte MSB first
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] r;
      r = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      end
      return r;
   endfunction

   always_comb begin
      state_d         = state_q;
      hdr_d           = hdr_q;
      crc_d           = crc_q;
      crc_rx_hi_d     = crc_rx_hi_q;
      idx_d           = idx_q;
      tmo_d           = '0;
      payload_buf_d   = payload_buf_q;
      payload_d       = payload_q;
      frame_valid_d   = 1'b0;
      crc_error_d     = 1'b0;
      frame_timeout_d = 1'b0;
      good_frames_d   = good_frames_q;
      bad_frames_d    = bad_frames_q;

      if (state_q == StHunt) begin
         if (rx_data_ready) begin
            hdr_d = {hdr_q[23:0], rx_data};
            if (hdr_d == MAGICNUMBER) begin
               crc_d   = 16'hFFFF;
               idx_d   = '0;
               state_d = StPayload;
            end
         end
      end else if (rx_data_ready) begin
         // A strobe in the last allowed cycle still counts as on time
         unique case (state_q)
            StPayload: begin
               for (int unsigned k = 0; k < PAYLOAD_BYTES; k++) begin
                  if (idx_q == IdxW'(k)) begin
                     payload_buf_d[8*k +: 8] = rx_data;
                  end
               end
               crc_d = crc16_byte(crc_q, rx_data);
               if (idx_q == LastIdx) begin
                  state_d = StCrcHi;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            StCrcHi: begin
               crc_rx_hi_d = rx_data;
               state_d     = StCrcLo;
            end
            StCrcLo: begin
               if ({crc_rx_hi_q, rx_data} == crc_q) begin
                  payload_d     = payload_buf_q;
                  frame_valid_d = 1'b1;
                  good_frames_d = good_frames_q + 16'd1;
               end else begin
                  crc_error_d  = 1'b1;
                  bad_frames_d = bad_frames_q + 16'd1;
               end
               hdr_d   = '0;
               state_d = StHunt;
            end
            default: state_d = StHunt;
         endcase
      end else if (tmo_q == TmoLast) begin
         frame_timeout_d = 1'b1;
         bad_frames_d    = bad_frames_q + 16'd1;
         hdr_d           = '0;
         state_d         = StHunt;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q         <= StHunt;
         hdr_q           <= '0;
         crc_q           <= '0;
         crc_rx_hi_q     <= '0;
         idx_q           <= '0;
         tmo_q           <= '0;
         payload_buf_q   <= '0;
         payload_q       <= '0;
         frame_valid_q   <= 1'b0;
         crc_error_q     <= 1'b0;
         frame_timeout_q <= 1'b0;
         good_frames_q   <= '0;
         bad_frames_q    <= '0;
      end else begin
         state_q         <= state_d;
         hdr_q           <= hdr_d;
         crc_q           <= crc_d;
         crc_rx_hi_q     <= crc_rx_hi_d;
         idx_q           <= idx_d;
         tmo_q           <= tmo_d;
         payload_buf_q   <= payload_buf_d;
         payload_q       <= payload_d;
         frame_valid_q   <= frame_valid_d;
         crc_error_q     <= crc_error_d;
         frame_timeout_q <= frame_timeout_d;
         good_frames_q   <= good_frames_d;
         bad_frames_q    <= bad_frames_d;
      end
   end

   assign payload       = payload_q;
   assign frame_valid   = frame_valid_q;
   assign crc_error     = crc_error_q;
   assign frame_timeout = frame_timeout_q;
   assign good_frames   = good_frames_q;
   assign bad_frames    = bad_frames_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed frames plus randomized frames against a frame-level model.
module tb_uart_frame_parser;

   localparam int unsigned PB    = 9;
   localparam int unsigned TMO   = 16000;
   localparam logic [31:0] MAGIC = 32'hDABBAD00;

   logic              clk = 1'b0;
   logic              reset;
   logic              rx_data_ready;
   logic [7:0]        rx_data;
   logic [8*PB-1:0]   payload;
   logic              frame_valid, crc_error, frame_timeout;
   logic [15:0]       good_frames, bad_frames;

   uart_frame_parser #(
      .PAYLOAD_BYTES (PB),
      .MAGICNUMBER   (MAGIC),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK          (clk),
      .reset        (reset),
      .rx_data_ready(rx_data_ready),
      .rx_data      (rx_data),
      .payload      (payload),
      .frame_valid  (frame_valid),
      .crc_error    (crc_error),
      .frame_timeout(frame_timeout),
      .good_frames  (good_frames),
      .bad_frames   (bad_frames)
   );

   always #5 clk = ~clk;

   int checks = 0, passes = 0;
   int n_valid = 0, n_crc = 0, n_tmo = 0, excl_viol = 0;
   int exp_good = 0, exp_bad = 0;
   logic [8*PB-1:0] exp_payload = '0;
   logic [7:0] pl [PB];

   always @(negedge clk) begin
      if (frame_valid) n_valid++;
      if (crc_error) n_crc++;
      if (frame_timeout) n_tmo++;
      if (int'(frame_valid) + int'(crc_error) + int'(frame_timeout) > 1) excl_viol++;
   end

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // Reference CRC, one message bit at a time over the payload
   function automatic logic [15:0] ref_crc();
      logic [15:0] c = 16'hFFFF;
      logic        fb;
      for (int k = 0; k < int'(PB); k++) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ pl[k][b];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   function automatic logic [8*PB-1:0] pack();
      logic [8*PB-1:0] v;
      for (int k = 0; k < int'(PB); k++) v[8*k +: 8] = pl[k];
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data       = b;
      rx_data_ready = 1'b1;
      @(posedge clk); #1;
      rx_data_ready = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_header(input int gmax);
      logic [31:0] m = MAGIC;
      for (int i = 0; i < 4; i++) send_byte(m[31-8*i -: 8], int'($urandom_range(gmax, 0)));
   endtask

   task automatic send_frame_bytes(input logic [15:0] crc_xor, input int gmax, input int long_gap);
      logic [15:0] c;
      c = ref_crc() ^ crc_xor;
      send_header(gmax);
      for (int k = 0; k < int'(PB); k++)
         send_byte(pl[k], (k == 0 && long_gap > 0) ? long_gap : int'($urandom_range(gmax, 0)));
      send_byte(c[15:8], int'($urandom_range(gmax, 0)));
      send_byte(c[7:0], 0);
   endtask

   task automatic run_frame(input logic [15:0] crc_xor, input int noise, input int gmax,
                            input int long_gap, input string tag);
      int v0, c0;
      bit bad;
      logic [7:0] b;
      v0  = n_valid;
      c0  = n_crc;
      bad = (crc_xor != 16'h0);
      for (int i = 0; i < noise; i++) begin
         b = 8'($urandom_range(255, 0));
         if (b == 8'hDA) b = 8'h00;
         send_byte(b, int'($urandom_range(gmax, 0)));
      end
      send_frame_bytes(crc_xor, gmax, long_gap);
      if (bad) exp_bad++;
      else begin
         exp_good++;
         exp_payload = pack();
      end
      check({tag, ".valid"}, frame_valid, !bad);
      check({tag, ".crcerr"}, crc_error, bad);
      check({tag, ".payload"}, payload, exp_payload);
      check({tag, ".good"}, good_frames, 16'(exp_good));
      check({tag, ".bad"}, bad_frames, 16'(exp_bad));
      @(posedge clk); #1;
      check({tag, ".vcnt"}, n_valid - v0, !bad);
      check({tag, ".ccnt"}, n_crc - c0, bad);
   endtask

   initial begin
      int t0, v0, c0, n_fire;
      logic [8*PB-1:0] p1, p2;
      reset         = 1'b1;
      rx_data_ready = 1'b0;
      rx_data       = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst.payload", payload, '0);
      check("rst.pulses", {frame_valid, crc_error, frame_timeout}, 3'b000);
      check("rst.cnt", {good_frames, bad_frames}, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // "123456789" -> CRC 29B1, then the same frame with 29B0
      for (int k = 0; k < int'(PB); k++) pl[k] = 8'h31 + 8'(k);
      run_frame(16'h0000, 0, 0, 0, "t1");
      check("t1.byte0", payload[7:0], 8'h31);
      check("t1.byte8", payload[71:64], 8'h39);
      run_frame(16'h0001, 0, 2, 0, "t2");

      // Overlapped header: DA DA BB AD 00
      send_byte(8'hDA, 0);
      for (int k = 0; k < int'(PB); k++) pl[k] = 8'($urandom_range(255, 0));
      run_frame(16'h0000, 0, 1, 0, "t3");

      // Truncated frame times out exactly TMO cycles after its last strobe
      t0 = n_tmo;
      send_header(0);
      for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(255, 0)), 0);
      n_fire = -1;
      for (int n = 1; n <= int'(TMO) + 5; n++) begin
         @(posedge clk); #1;
         if (frame_timeout) begin
            n_fire = n;
            break;
         end
      end
      exp_bad++;
      check("tmo.latency", n_fire, TMO);
      check("tmo.bad", bad_frames, 16'(exp_bad));
      check("tmo.good", good_frames, 16'(exp_good));
      check("tmo.payload", payload, exp_payload);
      @(posedge clk); #1;
      check("tmo.count", n_tmo - t0, 1);
      check("tmo.width", frame_timeout, 1'b0);
      for (int k = 0; k < int'(PB); k++) pl[k] = 8'($urandom_range(255, 0));
      run_frame(16'h0000, 2, 2, 0, "t4");

      // Gap of TMO-1 idle cycles: the strobe lands in the last allowed cycle
      t0 = n_tmo;
      for (int k = 0; k < int'(PB); k++) pl[k] = 8'($urandom_range(255, 0));
      run_frame(16'h0000, 0, 0, int'(TMO) - 1, "edge");
      check("edge.notmo", n_tmo - t0, 0);

      // Reset mid-payload
      send_header(1);
      send_byte(8'h55, 0);
      send_byte(8'hAA, 3);
      v0 = n_valid + n_crc + n_tmo;
      reset = 1'b1;
      #1;
      check("mid.payload", payload, '0);
      check("mid.cnt", {good_frames, bad_frames}, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("mid.pulses", {frame_valid, crc_error, frame_timeout}, 3'b000);
      reset = 1'b0;
      check("mid.nopulse", n_valid + n_crc + n_tmo - v0, 0);
      exp_good    = 0;
      exp_bad     = 0;
      exp_payload = '0;
      for (int k = 0; k < int'(PB); k++) pl[k] = 8'($urandom_range(255, 0));
      run_frame(16'h0000, 0, 1, 0, "t5");

      // Two frames with strobes on every cycle
      v0 = n_valid;
      for (int k = 0; k < int'(PB); k++) pl[k] = 8'($urandom_range(255, 0));
      p1 = pack();
      send_frame_bytes(16'h0000, 0, 0);
      check("b2b.valid1", frame_valid, 1'b1);
      check("b2b.payload1", payload, p1);
      for (int k = 0; k < int'(PB); k++) pl[k] = 8'($urandom_range(255, 0));
      p2 = pack();
      send_frame_bytes(16'h0000, 0, 0);
      exp_good += 2;
      exp_payload = p2;
      check("b2b.valid2", frame_valid, 1'b1);
      check("b2b.payload2", payload, p2);
      check("b2b.good", good_frames, 16'(exp_good));
      @(posedge clk); #1;
      check("b2b.vcnt", n_valid - v0, 2);

      // Randomized frames, roughly a quarter with a corrupted CRC
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < int'(PB); k++) pl[k] = 8'($urandom_range(255, 0));
         run_frame(($urandom_range(3, 0) == 0) ? 16'($urandom_range(65535, 1)) : 16'h0000,
                   int'($urandom_range(3, 0)), 3, 0, $sformatf("rnd%0d", i));
      end

      check("exclusive", excl_viol, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
